// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Bundles the receiver handshake and host-side FIFO signals of
//            uart_rx_fifo into one interface.
// Modports : master - receiver/host side (drives rx_data_i, rx_ready_i,
//                     read_i, clear_overflow_i; observes the rest)
//            slave  - the FIFO block itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data_i;
    logic                rx_ready_i;
    logic                rx_ack_o;
    logic                read_i;
    logic [7:0]          data_o;
    logic                empty_o;
    logic                full_o;
    logic [DEPTH_LOG2:0] count_o;
    logic                overflow_o;
    logic                clear_overflow_i;

    modport master (
        output rx_data_i, rx_ready_i, read_i, clear_overflow_i,
        input  rx_ack_o, data_o, empty_o, full_o, count_o, overflow_o
    );

    modport slave (
        input  rx_data_i, rx_ready_i, read_i, clear_overflow_i,
        output rx_ack_o, data_o, empty_o, full_o, count_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive FIFO behind a UART receiver. A three-state capture FSM
//            takes one byte per rx_ready_i assertion, acknowledges it with a
//            one-cycle rx_ack_o pulse and waits for rx_ready_i to drop before
//            accepting again. Bytes that find no room are dropped and flagged
//            on the sticky overflow_o. The head byte is presented
//            first-word-fall-through on data_o.
// Ports    : clock_i  - clock, rising edge
//            reset_i  - asynchronous active-high reset
//            bus      - uart_rx_fifo_if.slave (receiver handshake, host read
//                       port, status flags, occupancy count)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic          clock_i,
    input  wire logic          reset_i,
    uart_rx_fifo_if.slave      bus
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ACK        = 2'd1,
        S_WAIT_CLEAR = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ack;
    logic                  w_capture;

    logic [7:0]            r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [7:0]            r_data;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_space;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [7:0]            w_head_next;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_ready_i) begin
                    w_capture    = 1'b1;
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                w_ack        = 1'b1;
                w_state_next = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                // The receiver keeps ready high until it sees the ack; only
                // its release re-arms capture, so a byte is never taken twice.
                if (!bus.rx_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO datapath
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_COUNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.read_i && !w_empty;
    // A full FIFO still has room if the host pops in the same cycle.
    assign w_space = !w_full || bus.read_i;
    assign w_push  = w_capture && w_space;
    assign w_drop  = w_capture && !w_space;

    assign w_rd_ptr_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Registered head byte: the value mem[rd_ptr] will have after this edge.
    // If the new head slot is the one being written now, forward the input
    // byte (covers push into an empty FIFO and push+pop at count 1).
    always_comb begin
        w_head_next = r_data;
        if (w_count_next != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
                w_head_next = bus.rx_data_i;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    // Storage array carries no reset; its contents are only observed
    // through valid occupancy.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_data   <= w_head_next;
            // A drop in the same cycle as a clear request keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rx_ack_o   = w_ack;
    assign bus.data_o     = r_data;
    assign bus.empty_o    = w_empty;
    assign bus.full_o     = w_full;
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo (DEPTH_LOG2 = 4). A queue
//            based model tracks stored bytes, the sticky overflow flag and
//            the one-byte-per-ready-assertion handshake; a negedge monitor
//            compares every output each cycle. Directed scenarios add literal
//            expectations, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int ack_pulses = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue, sticky overflow, and the handshake
    // expressed as "ack due this cycle" / "waiting for ready to drop".
    // ------------------------------------------------------------------
    logic [7:0] q[$];
    bit m_ovf, m_ack, m_hold;
    bit m_cap, m_pop, m_spc;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_ack  = 1'b0;
            m_hold = 1'b0;
        end else begin
            m_cap = !m_ack && !m_hold && bus.rx_ready_i;
            m_pop = bus.read_i && (q.size() > 0);
            m_spc = (q.size() < DEPTH) || bus.read_i;
            if (m_pop) void'(q.pop_front());
            if (m_cap && m_spc) q.push_back(bus.rx_data_i);
            if (m_cap && !m_spc)       m_ovf = 1'b1;
            else if (bus.clear_overflow_i) m_ovf = 1'b0;
            if (m_cap) begin
                m_ack = 1'b1;
            end else if (m_ack) begin
                m_ack  = 1'b0;
                m_hold = 1'b1;
            end else if (m_hold && !bus.rx_ready_i) begin
                m_hold = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_ack_o) ack_pulses++;
            chk("ack",      bus.rx_ack_o,   m_ack);
            chk("count",    bus.count_o,    q.size());
            chk("empty",    bus.empty_o,    q.size() == 0);
            chk("full",     bus.full_o,     q.size() == DEPTH);
            chk("overflow", bus.overflow_o, m_ovf);
            if (q.size() != 0) chk("head", bus.data_o, q[0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_ready_i = 1'b1;
        tick();
        chk("send_ack", bus.rx_ack_o, 1);
        bus.rx_ready_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop();
        bus.read_i = 1'b1;
        tick();
        bus.read_i = 1'b0;
    endtask

    initial begin
        bus.rx_data_i        = 8'h00;
        bus.rx_ready_i       = 1'b0;
        bus.read_i           = 1'b0;
        bus.clear_overflow_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_count", bus.count_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full",  bus.full_o, 0);
        chk("rst_ovf",   bus.overflow_o, 0);
        chk("rst_ack",   bus.rx_ack_o, 0);
        chk("rst_data",  bus.data_o, 8'h00);
        rst = 1'b0;
        tick();

        // Single byte
        bus.rx_data_i  = 8'hA5;
        bus.rx_ready_i = 1'b1;
        tick();
        chk("a5_ack",   bus.rx_ack_o, 1);
        chk("a5_data",  bus.data_o, 8'hA5);
        chk("a5_count", bus.count_o, 1);
        chk("a5_empty", bus.empty_o, 0);
        bus.rx_ready_i = 1'b0;
        tick();
        chk("a5_ack_low", bus.rx_ack_o, 0);
        tick();
        pop();
        chk("a5_popped_empty", bus.empty_o, 1);

        // Fill to full, then one dropped byte
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        chk("fill_full",  bus.full_o, 1);
        chk("fill_count", bus.count_o, 16);
        bus.rx_data_i  = 8'hFF;
        bus.rx_ready_i = 1'b1;
        tick();
        chk("drop_ack", bus.rx_ack_o, 1);
        chk("drop_ovf", bus.overflow_o, 1);
        chk("drop_count", bus.count_o, 16);
        bus.rx_ready_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", bus.data_o, i);
            pop();
        end
        chk("drain_empty", bus.empty_o, 1);
        chk("drain_ovf_sticky", bus.overflow_o, 1);

        // Reset with content and overflow set
        for (int i = 0; i < 5; i++) send_byte(8'h80 + 8'(i));
        chk("pre_rst_count", bus.count_o, 5);
        chk("pre_rst_ovf",   bus.overflow_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", bus.count_o, 0);
        chk("async_rst_empty", bus.empty_o, 1);
        chk("async_rst_ovf",   bus.overflow_o, 0);
        chk("async_rst_data",  bus.data_o, 8'h00);
        tick();
        rst = 1'b0;
        pop();
        chk("empty_read_count", bus.count_o, 0);
        chk("empty_read_empty", bus.empty_o, 1);

        // Reset while ready held: byte captured anew after release
        bus.rx_data_i  = 8'h3C;
        bus.rx_ready_i = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", bus.count_o, 1);
        chk("post_rst_data",  bus.data_o, 8'h3C);
        bus.rx_ready_i = 1'b0;
        tick();
        tick();
        pop();

        // Ready held 10 cycles: one capture, one ack
        ack_pulses     = 0;
        bus.rx_data_i  = 8'hC3;
        bus.rx_ready_i = 1'b1;
        repeat (10) tick();
        bus.rx_ready_i = 1'b0;
        repeat (3) tick();
        chk("hold_ack_pulses", ack_pulses, 1);
        chk("hold_count", bus.count_o, 1);
        pop();

        // Full with simultaneous pop and capture
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i));
        bus.rx_data_i  = 8'h77;
        bus.rx_ready_i = 1'b1;
        bus.read_i     = 1'b1;
        tick();
        bus.rx_ready_i = 1'b0;
        bus.read_i     = 1'b0;
        chk("pp_ovf",   bus.overflow_o, 0);
        chk("pp_count", bus.count_o, 16);
        chk("pp_head",  bus.data_o, 8'h11);
        tick();
        tick();
        repeat (DEPTH - 1) pop();
        chk("pp_last", bus.data_o, 8'h77);
        pop();
        chk("pp_empty", bus.empty_o, 1);

        // 40 interleaved push/pop pairs across pointer wrap
        for (int i = 0; i < 40; i++) begin
            bus.rx_data_i  = 8'h40 + 8'(i);
            bus.rx_ready_i = 1'b1;
            bus.read_i     = (i % 3) != 0;
            tick();
            bus.rx_ready_i = 1'b0;
            bus.read_i     = 1'b0;
            tick();
            tick();
            chk("wrap_le_depth", bus.count_o <= 16, 1);
        end

        // Randomized traffic: fill-heavy then drain-heavy
        for (int i = 0; i < 800; i++) begin
            bus.rx_data_i        = 8'($urandom);
            bus.rx_ready_i       = ($urandom_range(0, 9) < 6);
            bus.read_i           = (i < 400) ? ($urandom_range(0, 9) < 2)
                                             : ($urandom_range(0, 9) < 7);
            bus.clear_overflow_i = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.rx_ready_i       = 1'b0;
        bus.read_i           = 1'b0;
        bus.clear_overflow_i = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving a FIFO depth of 2^DEPTH_LOG2 bytes (minimum value 1).
REQ-002 The block SHALL have port clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port rx_data_i, input, 8 bits: received byte from the receiver (UartRx data_o).
REQ-005 The block SHALL have port rx_ready_i, input, 1 bit: receiver holds a valid byte (UartRx ready_o).
REQ-006 The block SHALL have port rx_ack_o, output, 1 bit: one-cycle acknowledge to the receiver (UartRx ack_i).
REQ-007 The block SHALL have port read_i, input, 1 bit: host pops the head byte.
REQ-008 The block SHALL have port data_o, output, 8 bits: head byte, first-word-fall-through.
REQ-009 The block SHALL have port empty_o, output, 1 bit: FIFO holds 0 bytes.
REQ-010 The block SHALL have port full_o, output, 1 bit: FIFO holds 2^DEPTH_LOG2 bytes.
REQ-011 The block SHALL have port count_o, output, DEPTH_LOG2+1 bits: current occupancy.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: sticky dropped-byte flag.
REQ-013 The block SHALL have port clear_overflow_i, input, 1 bit: clears overflow_o.

Function
REQ-014 The capture FSM SHALL have three states: IDLE, ACK, WAIT_CLEAR.
REQ-015 In IDLE with rx_ready_i=1, the block SHALL capture rx_data_i into the FIFO if space exists and SHALL transition to ACK.
REQ-016 In ACK, the block SHALL drive rx_ack_o=1 for exactly that one cycle and SHALL transition to WAIT_CLEAR; rx_ack_o SHALL be 0 in all other states.
REQ-017 In WAIT_CLEAR, the block SHALL remain until rx_ready_i=0 and then return to IDLE, so that one byte is never captured twice.
REQ-018 Space SHALL exist when count_o < 2^DEPTH_LOG2, or when count_o = 2^DEPTH_LOG2 and read_i pops in the same cycle.
REQ-019 If no space exists at capture, the byte SHALL be dropped, overflow_o SHALL be set the next cycle, and the acknowledge sequence SHALL still occur.
REQ-020 A captured byte SHALL appear on data_o, with empty_o=0, on the cycle after capture when the FIFO was empty.
REQ-021 read_i with empty_o=1 SHALL be ignored: no pointer or count change and no underflow.
REQ-022 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-023 Read and write pointers SHALL be DEPTH_LOG2 bits wide and SHALL wrap modulo 2^DEPTH_LOG2.
REQ-024 count_o SHALL saturate at neither end: it is held within 0..2^DEPTH_LOG2 by REQ-018 and REQ-021.
REQ-025 full_o and empty_o SHALL be derived from count_o combinationally or registered, and SHALL be consistent with count_o in the same cycle.
REQ-026 data_o SHALL hold its last value when the FIFO is empty; its value is don't-care for checking while empty_o=1.
REQ-027 clear_overflow_i SHALL clear overflow_o the next cycle; if a drop occurs in the same cycle, set SHALL win.

Reset
REQ-028 While reset_i=1, asynchronously: FSM=IDLE, pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, rx_ack_o=0, data_o=8'h00.
REQ-029 Reset mid-operation SHALL discard all stored bytes; if rx_ready_i is still 1 after reset release, that byte SHALL be captured as new.

Verification
REQ-030 Single byte: rx_data_i=8'hA5 with rx_ready_i pulse -> rx_ack_o high one cycle, data_o=8'hA5, count_o=1; read_i -> empty_o=1.
REQ-031 Fill (DEPTH_LOG2=4): 16 bytes 8'h00..8'h0F -> full_o=1, count_o=16; 17th byte 8'hFF -> dropped, overflow_o=1, rx_ack_o still pulses; pops yield 8'h00..8'h0F in order.
REQ-032 Full plus simultaneous pop and capture -> no overflow, count_o stays 16, new byte is last out.
REQ-033 Hold rx_ready_i=1 for 10 cycles -> exactly one capture and one rx_ack_o pulse.
REQ-034 Wrap: 40 push/pop pairs with interleaving -> data order preserved and count_o never exceeds 16.
REQ-035 Reset asserted with count_o=5 and overflow_o=1 -> immediately count_o=0, empty_o=1, overflow_o=0; read_i on empty -> no change.
